// File: rtl/gigabit_tx_frame_fifo.sv
// -----------------------------------------------------------------------------
// gigabit_tx_frame_fifo
//
// Per-port egress frame buffer between the switch fabric and a 1G MAC TX.
// Everything runs in the MAC clock domain. Whole frames are written into a
// data RAM. When a frame is committed, its byte length is pushed into a small
// length FIFO. The read side transmits a frame only once it is committed
// (store-and-forward). Aborted, oversized or overflowing frames are removed by
// rewinding the write pointer, so they never reach the MAC.
//
// Optional feature macro: GIGABIT_TX_FRAME_FIFO_STATS_EN
//   When this macro is defined, the block adds the stat_frames_sent_o and
//   stat_bytes_sent_o wrapping counters.
//
// Ports
//   clk_i              MAC clock
//   rst_i              synchronous active-high reset
//   wr_start_i         begin a new frame (discards any uncommitted frame)
//   wr_valid_i         wr_data_i carries wr_bytes_i valid bytes, MSB-first
//   wr_bytes_i         1..4 (less than 4 only on the last word)
//   wr_data_i          frame data word
//   wr_commit_i        end of frame, keep it
//   wr_drop_i          end of frame, discard it
//   tx_ready_i         MAC can accept a new frame
//   tx_start_o         one-cycle pulse; first data word follows next cycle
//   tx_data_valid_o    tx_data_o is valid
//   tx_bytes_valid_o   valid bytes in tx_data_o (1..4)
//   tx_data_o          frame data word, MSB-first
//   tx_commit_o        one-cycle pulse after the last word
//   drop_overflow_o    pulse: frame lost because data or length space ran out
//   drop_jumbo_o       pulse: frame lost because it exceeds MAX_BYTES
//   frames_pending_o   committed frames that are not yet fully sent
//   stat_frames_sent_o (macro only) frames completed
//   stat_bytes_sent_o  (macro only) bytes completed
// -----------------------------------------------------------------------------
module gigabit_tx_frame_fifo #(
  parameter int DATA_DEPTH = 1024,
  parameter int META_DEPTH = 32,
  parameter int MAX_BYTES  = 1518
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_start_i,
  input  logic                          wr_valid_i,
  input  logic [2:0]                    wr_bytes_i,
  input  logic [31:0]                   wr_data_i,
  input  logic                          wr_commit_i,
  input  logic                          wr_drop_i,
  input  logic                          tx_ready_i,
  output logic                          tx_start_o,
  output logic                          tx_data_valid_o,
  output logic [2:0]                    tx_bytes_valid_o,
  output logic [31:0]                   tx_data_o,
  output logic                          tx_commit_o,
  output logic                          drop_overflow_o,
  output logic                          drop_jumbo_o,
  output logic [$clog2(META_DEPTH):0]   frames_pending_o
`ifdef GIGABIT_TX_FRAME_FIFO_STATS_EN
  ,
  output logic [31:0]                   stat_frames_sent_o,
  output logic [31:0]                   stat_bytes_sent_o
`endif
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int MW = $clog2(META_DEPTH);
  localparam logic [AW:0] DATA_FULL = (AW+1)'(DATA_DEPTH);
  localparam logic [MW:0] META_FULL = (MW+1)'(META_DEPTH);
  localparam logic [10:0] MAX_LEN   = 11'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_COMMIT,
    S_GAP
  } tx_state_e;

  // Number of 32-bit words that hold a frame of len bytes.
  function automatic logic [9:0] words_of(input logic [10:0] len);
    return {1'b0, len[10:2]} + {9'd0, |len[1:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] data_mem [DATA_DEPTH];
  logic [10:0] meta_mem [META_DEPTH];
  logic [31:0] ram_q;

  // ---------------------------------------------------------------------------
  // Write-side state
  // ---------------------------------------------------------------------------
  // Pointers are one bit wider than the address so that a full buffer can be
  // distinguished from an empty one.
  logic          in_frame_q;
  logic          fail_q;
  logic [10:0]   len_q;
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   frame_base_q;
  logic          drop_overflow_q;
  logic          drop_jumbo_q;

  // Length FIFO state
  logic [MW-1:0] meta_wr_q;
  logic [MW-1:0] meta_rd_q;
  logic [MW:0]   meta_count_q;

  // Read-side state
  tx_state_e     state_q;
  logic [AW:0]   crd_q;          // start of the oldest frame not yet released
  logic [AW-1:0] rd_addr_q;
  logic [10:0]   cur_len_q;
  logic [9:0]    words_left_q;
  logic [1:0]    gap_cnt_q;
  logic          tx_start_q;
  logic          tx_valid_q;
  logic [2:0]    tx_bytes_q;
  logic [31:0]   tx_data_q;
  logic          tx_commit_q;

  // ---------------------------------------------------------------------------
  // Write-side decisions
  // ---------------------------------------------------------------------------
  logic [AW:0]   used_words;
  logic          data_full;
  logic          word_in;
  logic          word_store;
  logic [11:0]   len_sum;
  logic [10:0]   len_acc;
  logic          fail_acc;
  logic          end_commit;
  logic          end_drop;
  logic          meta_full;
  logic          push;
  logic          pop;
  logic          ovf;
  logic          jumbo;
  logic          rewind;
  logic [AW:0]   start_base;
  logic [AW:0]   wr_ptr_adv;

  // Space is only released when a frame finishes transmitting. As a result,
  // the frame currently on the wire still counts as occupied.
  assign used_words = wr_ptr_q - crd_q;
  assign data_full  = (used_words == DATA_FULL);
  assign meta_full  = (meta_count_q == META_FULL);

  // wr_start_i takes the cycle for itself. Data and end controls are ignored
  // outside a frame.
  assign word_in    = in_frame_q && wr_valid_i && !wr_start_i;
  assign word_store = word_in && !data_full;
  assign wr_ptr_adv = wr_ptr_q + {{AW{1'b0}}, word_store};

  // A word in the commit cycle is counted before the commit is judged.
  assign len_sum  = {1'b0, len_q} + {9'd0, wr_bytes_i};
  assign len_acc  = !word_in ? len_q : (len_sum[11] ? 11'h7FF : len_sum[10:0]);
  assign fail_acc = fail_q || (word_in && data_full);

  assign end_drop   = in_frame_q && !wr_start_i && wr_drop_i;
  assign end_commit = in_frame_q && !wr_start_i && wr_commit_i && !wr_drop_i;

  // A restart rewinds over the abandoned frame, so committed frames stay
  // contiguous in RAM.
  assign start_base = in_frame_q ? frame_base_q : wr_ptr_q;

  // NOTE: every output of a combinational block gets a default value first;
  // otherwise a path that leaves it unassigned infers a latch.
  always_comb begin
    push  = 1'b0;
    ovf   = 1'b0;
    jumbo = 1'b0;
    // A zero-length commit falls through all three branches. It is
    // discarded without a pulse.
    if (end_commit && len_acc != 11'd0) begin
      if (fail_acc || meta_full) begin
        ovf = 1'b1;
      end else if (len_acc > MAX_LEN) begin
        jumbo = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  assign rewind = end_drop || (end_commit && !push);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the values from before the clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_frame_q      <= 1'b0;
      fail_q          <= 1'b0;
      len_q           <= '0;
      wr_ptr_q        <= '0;
      frame_base_q    <= '0;
      drop_overflow_q <= 1'b0;
      drop_jumbo_q    <= 1'b0;
    end else begin
      drop_overflow_q <= ovf;
      drop_jumbo_q    <= jumbo;
      if (wr_start_i) begin
        in_frame_q   <= 1'b1;
        fail_q       <= 1'b0;
        len_q        <= '0;
        frame_base_q <= start_base;
        wr_ptr_q     <= start_base;
      end else if (in_frame_q) begin
        len_q  <= len_acc;
        fail_q <= fail_acc;
        if (rewind) begin
          wr_ptr_q   <= frame_base_q;
          in_frame_q <= 1'b0;
        end else begin
          wr_ptr_q <= wr_ptr_adv;
          if (end_commit) in_frame_q <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Length FIFO
  // ---------------------------------------------------------------------------
  assign pop = (state_q == S_IDLE) && (meta_count_q != '0) && tx_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_wr_q    <= '0;
      meta_rd_q    <= '0;
      meta_count_q <= '0;
    end else begin
      if (push) meta_wr_q <= meta_wr_q + 1'b1;
      if (pop)  meta_rd_q <= meta_rd_q + 1'b1;
      case ({push, pop})
        2'b10:   meta_count_q <= meta_count_q + 1'b1;
        2'b01:   meta_count_q <= meta_count_q - 1'b1;
        default: meta_count_q <= meta_count_q;
      endcase
    end
  end

  // NOTE: memory arrays are not reset. The pointers and counts decide what is
  // valid, and leaving the arrays unreset lets them map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (push) meta_mem[meta_wr_q] <= len_acc;
  end

  // ---------------------------------------------------------------------------
  // Data RAM: one write port and one registered read port
  // ---------------------------------------------------------------------------
  logic [AW-1:0] raddr;
  assign raddr = pop ? crd_q[AW-1:0] : rd_addr_q;

  always_ff @(posedge clk_i) begin
    if (word_store) data_mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    ram_q <= data_mem[raddr];
  end

  // ---------------------------------------------------------------------------
  // Read-side FSM
  // ---------------------------------------------------------------------------
  logic [10:0] head_len;
  logic [1:0]  len_m1;
  logic [2:0]  last_bytes;

  assign head_len   = meta_mem[meta_rd_q];
  assign len_m1     = cur_len_q[1:0] - 2'd1;
  assign last_bytes = {1'b0, len_m1} + 3'd1;

`ifdef GIGABIT_TX_FRAME_FIFO_STATS_EN
  logic [31:0] stat_frames_q;
  logic [31:0] stat_bytes_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      crd_q        <= '0;
      rd_addr_q    <= '0;
      cur_len_q    <= '0;
      words_left_q <= '0;
      gap_cnt_q    <= '0;
      tx_start_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_bytes_q   <= '0;
      tx_data_q    <= '0;
      tx_commit_q  <= 1'b0;
`ifdef GIGABIT_TX_FRAME_FIFO_STATS_EN
      stat_frames_q <= '0;
      stat_bytes_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            // Word 0 is read now, so it is already in ram_q during START.
            state_q      <= S_START;
            tx_start_q   <= 1'b1;
            cur_len_q    <= head_len;
            words_left_q <= words_of(head_len) - 10'd1;
            rd_addr_q    <= crd_q[AW-1:0] + 1'b1;
          end
        end
        S_START: begin
          state_q    <= S_DATA;
          tx_start_q <= 1'b0;
          tx_valid_q <= 1'b1;
          tx_data_q  <= ram_q;
          tx_bytes_q <= (words_left_q == 10'd0) ? last_bytes : 3'd4;
          rd_addr_q  <= rd_addr_q + 1'b1;
        end
        S_DATA: begin
          if (words_left_q == 10'd0) begin
            state_q     <= S_COMMIT;
            tx_valid_q  <= 1'b0;
            tx_bytes_q  <= '0;
            tx_data_q   <= '0;
            tx_commit_q <= 1'b1;
          end else begin
            words_left_q <= words_left_q - 10'd1;
            tx_data_q    <= ram_q;
            tx_bytes_q   <= (words_left_q == 10'd1) ? last_bytes : 3'd4;
            rd_addr_q    <= rd_addr_q + 1'b1;
          end
        end
        S_COMMIT: begin
          state_q     <= S_GAP;
          tx_commit_q <= 1'b0;
          gap_cnt_q   <= 2'd2;
          crd_q       <= crd_q + (AW+1)'(words_of(cur_len_q));
`ifdef GIGABIT_TX_FRAME_FIFO_STATS_EN
          stat_frames_q <= stat_frames_q + 32'd1;
          stat_bytes_q  <= stat_bytes_q + 32'(cur_len_q);
`endif
        end
        S_GAP: begin
          if (gap_cnt_q == 2'd0) state_q <= S_IDLE;
          else                   gap_cnt_q <= gap_cnt_q - 2'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic busy;
  assign busy = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_COMMIT);

  assign tx_start_o       = tx_start_q;
  assign tx_data_valid_o  = tx_valid_q;
  assign tx_bytes_valid_o = tx_bytes_q;
  assign tx_data_o        = tx_data_q;
  assign tx_commit_o      = tx_commit_q;
  assign drop_overflow_o  = drop_overflow_q;
  assign drop_jumbo_o     = drop_jumbo_q;
  assign frames_pending_o = meta_count_q + {{MW{1'b0}}, busy};

`ifdef GIGABIT_TX_FRAME_FIFO_STATS_EN
  assign stat_frames_sent_o = stat_frames_q;
  assign stat_bytes_sent_o  = stat_bytes_q;
`endif

endmodule

// File: tb/tb_gigabit_tx_frame_fifo.sv
// -----------------------------------------------------------------------------
// Bench for gigabit_tx_frame_fifo.
// The reference model keeps a list of the frames expected on the MAC side,
// stored as byte queues, and expected counts of drop pulses. A monitor
// rebuilds the frames it observes from the TX outputs. Drained frames are then
// compared with the model, one frame at a time.
// -----------------------------------------------------------------------------
module tb_gigabit_tx_frame_fifo;

  localparam int MAX_BYTES  = 1518;
  localparam int META_DEPTH = 32;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wr_start_i;
  logic        wr_valid_i;
  logic [2:0]  wr_bytes_i;
  logic [31:0] wr_data_i;
  logic        wr_commit_i;
  logic        wr_drop_i;
  logic        tx_ready_i;
  logic        tx_start_o;
  logic        tx_data_valid_o;
  logic [2:0]  tx_bytes_valid_o;
  logic [31:0] tx_data_o;
  logic        tx_commit_o;
  logic        drop_overflow_o;
  logic        drop_jumbo_o;
  logic [5:0]  frames_pending_o;
`ifdef GIGABIT_TX_FRAME_FIFO_STATS_EN
  logic [31:0] stat_frames_sent_o;
  logic [31:0] stat_bytes_sent_o;
`endif

  always #4 clk_i = ~clk_i;

  gigabit_tx_frame_fifo dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .wr_start_i       (wr_start_i),
    .wr_valid_i       (wr_valid_i),
    .wr_bytes_i       (wr_bytes_i),
    .wr_data_i        (wr_data_i),
    .wr_commit_i      (wr_commit_i),
    .wr_drop_i        (wr_drop_i),
    .tx_ready_i       (tx_ready_i),
    .tx_start_o       (tx_start_o),
    .tx_data_valid_o  (tx_data_valid_o),
    .tx_bytes_valid_o (tx_bytes_valid_o),
    .tx_data_o        (tx_data_o),
    .tx_commit_o      (tx_commit_o),
    .drop_overflow_o  (drop_overflow_o),
    .drop_jumbo_o     (drop_jumbo_o),
    .frames_pending_o (frames_pending_o)
`ifdef GIGABIT_TX_FRAME_FIFO_STATS_EN
    ,
    .stat_frames_sent_o (stat_frames_sent_o),
    .stat_bytes_sent_o  (stat_bytes_sent_o)
`endif
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  // Reference model
  byte unsigned exp_bytes[$];
  int           exp_lens[$];
  int           ovf_exp   = 0;
  int           jumbo_exp = 0;

  // Observed traffic
  byte unsigned rx_bytes[$];
  byte unsigned cur_bytes[$];
  int           rx_lens[$];
  int           rx_words[$];
  int           rx_lastbv[$];
  int           start_cycles[$];
  int           commit_cycles[$];
  int           cur_words  = 0;
  int           cur_lastbv = 0;
  int           ovf_cnt    = 0;
  int           jumbo_cnt  = 0;

  bit rand_ready = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rst_i) begin
      cur_bytes.delete();
      cur_words = 0;
    end else begin
      if (tx_start_o) begin
        start_cycles.push_back(cyc);
        cur_bytes.delete();
        cur_words  = 0;
        cur_lastbv = 0;
      end
      if (tx_data_valid_o) begin
        for (int k = 0; k < int'(tx_bytes_valid_o) && k < 4; k++)
          cur_bytes.push_back(tx_data_o[31-8*k -: 8]);
        cur_words++;
        cur_lastbv = int'(tx_bytes_valid_o);
      end
      if (tx_commit_o) begin
        rx_lens.push_back(cur_bytes.size());
        rx_words.push_back(cur_words);
        rx_lastbv.push_back(cur_lastbv);
        commit_cycles.push_back(cyc);
        foreach (cur_bytes[k]) rx_bytes.push_back(cur_bytes[k]);
        cur_bytes.delete();
      end
      if (drop_overflow_o) ovf_cnt++;
      if (drop_jumbo_o)    jumbo_cnt++;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_ready) tx_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  // mode 0: commit with last word, 1: separate commit cycle,
  // 2: wr_drop half way, 3: abandoned (the next wr_start discards it)
  task automatic write_frame(input int n, input int mode);
    byte unsigned fb[$];
    int nw;
    int nwr;
    bit committed;
    logic [31:0] w;
    committed = 1'b0;
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
    nw  = (n + 3) / 4;
    nwr = (mode >= 2) ? nw / 2 : nw;
    wr_start_i = 1'b1;
    tick();
    wr_start_i = 1'b0;
    for (int wi = 0; wi < nwr; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (4*wi + k < n) w[31-8*k -: 8] = fb[4*wi + k];
      wr_valid_i = 1'b1;
      wr_bytes_i = 3'((n - 4*wi) >= 4 ? 4 : (n - 4*wi));
      wr_data_i  = w;
      if (mode == 0 && wi == nw - 1) begin
        wr_commit_i = 1'b1;
        committed   = 1'b1;
      end
      tick();
      wr_valid_i  = 1'b0;
      wr_commit_i = 1'b0;
    end
    if (mode <= 1 && !committed) begin
      wr_commit_i = 1'b1;
      tick();
      wr_commit_i = 1'b0;
    end
    if (mode == 2) begin
      wr_drop_i = 1'b1;
      tick();
      wr_drop_i = 1'b0;
    end
    if (mode <= 1 && n > 0) begin
      if (n > MAX_BYTES) jumbo_exp++;
      else if (exp_lens.size() >= META_DEPTH) ovf_exp++;
      else begin
        exp_lens.push_back(n);
        foreach (fb[i]) exp_bytes.push_back(fb[i]);
      end
    end
  endtask

  task automatic compare_ready();
    while (rx_lens.size() > 0 && exp_lens.size() > 0) begin
      int rl;
      int el;
      int bad;
      rl  = rx_lens.pop_front();
      el  = exp_lens.pop_front();
      bad = 0;
      check("frame_len", rl, el);
      check("frame_words", rx_words.pop_front(), (el + 3) / 4);
      check("last_bytes_valid", rx_lastbv.pop_front(), ((el - 1) % 4) + 1);
      for (int i = 0; i < el; i++) begin
        byte unsigned e;
        e = exp_bytes.pop_front();
        if (i < rl && rx_bytes.size() > 0)
          if (rx_bytes.pop_front() !== e) bad++;
      end
      for (int i = el; i < rl; i++)
        if (rx_bytes.size() > 0) void'(rx_bytes.pop_front());
      check("frame_bytes_bad", bad, 0);
    end
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (rx_lens.size() < exp_lens.size() && t < budget) begin
      tick();
      t++;
    end
    repeat (8) tick();
    check("frame_count", rx_lens.size(), exp_lens.size());
    compare_ready();
  endtask

  initial begin
    int sc0;
    int cc0;
    int c0;
    int t;
    rst_i       = 1'b1;
    wr_start_i  = 1'b0;
    wr_valid_i  = 1'b0;
    wr_bytes_i  = '0;
    wr_data_i   = '0;
    wr_commit_i = 1'b0;
    wr_drop_i   = 1'b0;
    tx_ready_i  = 1'b0;
    repeat (3) tick();
    check("rst_tx_start", tx_start_o, 0);
    check("rst_tx_valid", tx_data_valid_o, 0);
    check("rst_tx_commit", tx_commit_o, 0);
    check("rst_pending", frames_pending_o, 0);
    check("rst_drop_ovf", drop_overflow_o, 0);
    check("rst_drop_jumbo", drop_jumbo_o, 0);
    rst_i = 1'b0;
    tick();

    // 64-byte frame, MAC ready
    tx_ready_i = 1'b1;
    sc0 = start_cycles.size();
    write_frame(64, 0);
    drain(500);
    check("start_pulses_64", start_cycles.size() - sc0, 1);

    // 61-byte frame then 64-byte frame, queued while the MAC is busy
    tx_ready_i = 1'b0;
    sc0 = start_cycles.size();
    cc0 = commit_cycles.size();
    write_frame(61, 1);
    write_frame(64, 0);
    tick();
    check("pending_two", frames_pending_o, exp_lens.size());
    tx_ready_i = 1'b1;
    drain(500);
    check("ifg_ge4", (start_cycles[sc0+1] - commit_cycles[cc0]) >= 4, 1);

    // Fill the length FIFO, and the 33rd frame overflows
    tx_ready_i = 1'b0;
    repeat (32) write_frame(64, 0);
    repeat (2) tick();
    check("pending_32", frames_pending_o, exp_lens.size());
    write_frame(64, 0);
    repeat (2) tick();
    check("meta_overflow", ovf_cnt, ovf_exp);
    check("pending_after_ovf", frames_pending_o, exp_lens.size());
    tx_ready_i = 1'b1;
    drain(5000);

    // Jumbo frame, then a frame exactly at the limit and a normal frame
    sc0 = start_cycles.size();
    write_frame(1519, 0);
    repeat (4) tick();
    check("jumbo_drop", jumbo_cnt, jumbo_exp);
    check("jumbo_no_start", start_cycles.size() - sc0, 0);
    write_frame(64, 0);
    write_frame(MAX_BYTES, 1);
    drain(3000);

    // wr_drop mid-frame, then a new frame; a zero-length commit after that
    write_frame(100, 2);
    write_frame(64, 0);
    write_frame(0, 1);
    repeat (3) tick();
    check("no_spurious_ovf", ovf_cnt, ovf_exp);
    drain(500);

    // Randomized traffic with a randomly stalling MAC
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int r;
      t = 0;
      while (frames_pending_o > 3 && t < 2000) begin
        tick();
        t++;
      end
      check("pace_wait", frames_pending_o <= 3, 1);
      r = $urandom_range(0, 9);
      if (r < 6)       write_frame($urandom_range(1, 400), $urandom_range(0, 1));
      else if (r < 8)  write_frame($urandom_range(4, 400), 2);
      else if (r == 8) write_frame($urandom_range(8, 200), 3);
      else             write_frame(MAX_BYTES + 1 + $urandom_range(0, 20), 0);
      compare_ready();
    end
    rand_ready = 1'b0;
    tx_ready_i = 1'b1;
    drain(5000);
    check("ovf_total", ovf_cnt, ovf_exp);
    check("jumbo_total", jumbo_cnt, jumbo_exp);

    // Reset in the middle of DATA abandons the frame
    write_frame(200, 0);
    exp_lens.pop_back();
    repeat (200) void'(exp_bytes.pop_back());
    t = 0;
    while (!tx_data_valid_o && t < 200) begin
      tick();
      t++;
    end
    check("reached_data", tx_data_valid_o, 1);
    repeat (5) tick();
    c0 = commit_cycles.size();
    rst_i = 1'b1;
    tick();
    check("rstd_tx_valid", tx_data_valid_o, 0);
    check("rstd_tx_data", tx_data_o, 0);
    check("rstd_tx_bytes", tx_bytes_valid_o, 0);
    check("rstd_tx_start", tx_start_o, 0);
    check("rstd_tx_commit", tx_commit_o, 0);
    check("rstd_pending", frames_pending_o, 0);
    rst_i = 1'b0;
    repeat (80) tick();
    check("rstd_no_commit", commit_cycles.size() - c0, 0);
    write_frame(64, 0);
    drain(500);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
